// File: rtl/adxl362_controller_if.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// adxl362_controller_if
//   Request/response bus between the user-facing logic and the ADXL362
//   transaction engine.
//
//   Handshake: the requester raises start for at least one cycle while busy is
//   low; the engine samples start, write, address and data_to_send only while
//   idle, so these must be valid in the same cycle as start.  busy rises the
//   cycle after acceptance and stays high until the engine is idle again.  done
//   is a single-cycle pulse at frame completion; for reads, data_received
//   carries the returned byte from that cycle until the next read completes.
//
//   Signals:
//     start          requester -> engine  request strobe
//     write          requester -> engine  1 = register write, 0 = register read
//     address[7:0]   requester -> engine  register address
//     data_to_send   requester -> engine  write data (ignored for reads)
//     busy           engine -> requester  frame in progress
//     done           engine -> requester  one-cycle completion pulse
//     data_received  engine -> requester  last byte read from the device
// -----------------------------------------------------------------------------
interface adxl362_controller_if;
    logic       start;
    logic       write;
    logic [7:0] address;
    logic [7:0] data_to_send;
    logic       busy;
    logic       done;
    logic [7:0] data_received;

    modport master (
        output start,
        output write,
        output address,
        output data_to_send,
        input  busy,
        input  done,
        input  data_received
    );

    modport slave (
        input  start,
        input  write,
        input  address,
        input  data_to_send,
        output busy,
        output done,
        output data_received
    );
endinterface

// File: rtl/adxl362_controller.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// adxl362_controller
//   Single-register read/write engine for the ADXL362 accelerometer.  Each
//   request becomes one 3-byte SPI mode-0 frame (command, address, data) with
//   CS_N held low across all 24 bits.  Command 0x0A writes, 0x0B reads.  The
//   byte shifted in during the data phase of a read is returned on the request
//   bus together with a one-cycle done pulse.
//
//   Parameters:
//     CLK_FREQUENCY   system clock in Hz
//     SCLK_FREQUENCY  SPI clock in Hz; HALF = CLK_FREQUENCY/(2*SCLK_FREQUENCY)
//                     clocks per SCLK phase, must be at least 2
//
//   Ports:
//     clk, rst_n      system clock, asynchronous active-low reset
//     req             request/response bus (slave side)
//     SPI_SCLK        serial clock, idle low
//     SPI_MOSI        serial data to device, MSB first
//     SPI_MISO        serial data from device
//     SPI_CS          active-low chip select, idle high
//     dbg_state       current FSM state (0 idle, 1 low, 2 high, 3 hold, 4 gap)
//
//   Frame timing: LOW/HIGH alternate 24 times (HALF clocks each), then HOLD
//   keeps CS_N low with SCLK low for HALF clocks, then GAP keeps CS_N high for
//   HALF clocks before the engine accepts another request.  done is raised on
//   the first GAP cycle, so it appears one clock after CS_N deasserts.
// -----------------------------------------------------------------------------
module adxl362_controller #(
    parameter int CLK_FREQUENCY  = 100_000_000,
    parameter int SCLK_FREQUENCY = 1_000_000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    adxl362_controller_if.slave        req,
    output logic                       SPI_SCLK,
    output logic                       SPI_MOSI,
    input  logic                       SPI_MISO,
    output logic                       SPI_CS,
    output logic [2:0]                 dbg_state
);

    localparam int HALF  = CLK_FREQUENCY / (2 * SCLK_FREQUENCY);
    localparam int CNT_W = (HALF > 2) ? $clog2(HALF) : 1;

    localparam logic [7:0] CMD_WRITE = 8'h0A;
    localparam logic [7:0] CMD_READ  = 8'h0B;

    if (HALF < 2) begin : g_half_check
        $error("adxl362_controller: CLK_FREQUENCY/(2*SCLK_FREQUENCY) must be >= 2");
    end

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOW  = 3'd1,
        ST_HIGH = 3'd2,
        ST_HOLD = 3'd3,
        ST_GAP  = 3'd4
    } state_t;

    state_t             state_q,     state_d;
    logic [CNT_W-1:0]   phase_cnt_q, phase_cnt_d;
    logic [4:0]         bit_cnt_q,   bit_cnt_d;
    logic [23:0]        tx_q,        tx_d;
    logic [7:0]         rx_q,        rx_d;
    logic               is_read_q,   is_read_d;
    logic               sclk_q,      sclk_d;
    logic               mosi_q,      mosi_d;
    logic               cs_q,        cs_d;
    logic               busy_q,      busy_d;
    logic               done_q,      done_d;
    logic [7:0]         data_rx_q,   data_rx_d;

    logic               phase_last;

    assign phase_last = (phase_cnt_q == CNT_W'(HALF - 1));

    always_comb begin
        state_d     = state_q;
        phase_cnt_d = phase_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        is_read_d   = is_read_q;
        sclk_d      = sclk_q;
        mosi_d      = mosi_q;
        cs_d        = cs_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        data_rx_d   = data_rx_q;

        case (state_q)
            ST_IDLE: begin
                if (req.start) begin
                    is_read_d   = ~req.write;
                    tx_d        = {req.write ? CMD_WRITE : CMD_READ,
                                   req.address,
                                   req.write ? req.data_to_send : 8'h00};
                    bit_cnt_d   = 5'd0;
                    phase_cnt_d = '0;
                    state_d     = ST_LOW;
                    cs_d        = 1'b0;
                    sclk_d      = 1'b0;
                    mosi_d      = tx_d[23];
                    busy_d      = 1'b1;
                end
            end

            ST_LOW: begin
                phase_cnt_d = phase_cnt_q + 1'b1;
                if (phase_last) begin
                    phase_cnt_d = '0;
                    sclk_d      = 1'b1;
                    state_d     = ST_HIGH;
                end
            end

            ST_HIGH: begin
                phase_cnt_d = phase_cnt_q + 1'b1;
                if (phase_last) begin
                    // MISO has been stable since the previous falling edge;
                    // sampling at the end of the high phase gives the device
                    // the whole phase to settle.
                    phase_cnt_d = '0;
                    rx_d        = {rx_q[6:0], SPI_MISO};
                    sclk_d      = 1'b0;
                    if (bit_cnt_q == 5'd23) begin
                        state_d = ST_HOLD;
                    end else begin
                        // Next bit goes out together with the falling edge,
                        // so MOSI never moves while SCLK is high.
                        tx_d      = {tx_q[22:0], 1'b0};
                        mosi_d    = tx_q[22];
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        state_d   = ST_LOW;
                    end
                end
            end

            ST_HOLD: begin
                phase_cnt_d = phase_cnt_q + 1'b1;
                if (phase_last) begin
                    phase_cnt_d = '0;
                    cs_d        = 1'b1;
                    mosi_d      = 1'b0;
                    state_d     = ST_GAP;
                end
            end

            ST_GAP: begin
                phase_cnt_d = phase_cnt_q + 1'b1;
                if (phase_cnt_q == '0) begin
                    done_d = 1'b1;
                    if (is_read_q) begin
                        data_rx_d = rx_q;
                    end
                end
                if (phase_last) begin
                    phase_cnt_d = '0;
                    busy_d      = 1'b0;
                    state_d     = ST_IDLE;
                end
            end

            default: begin
                state_d     = ST_IDLE;
                phase_cnt_d = '0;
                cs_d        = 1'b1;
                sclk_d      = 1'b0;
                mosi_d      = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            phase_cnt_q <= '0;
            bit_cnt_q   <= 5'd0;
            tx_q        <= 24'h000000;
            rx_q        <= 8'h00;
            is_read_q   <= 1'b0;
            sclk_q      <= 1'b0;
            mosi_q      <= 1'b0;
            cs_q        <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            data_rx_q   <= 8'h00;
        end else begin
            state_q     <= state_d;
            phase_cnt_q <= phase_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            is_read_q   <= is_read_d;
            sclk_q      <= sclk_d;
            mosi_q      <= mosi_d;
            cs_q        <= cs_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            data_rx_q   <= data_rx_d;
        end
    end

    assign SPI_SCLK          = sclk_q;
    assign SPI_MOSI          = mosi_q;
    assign SPI_CS            = cs_q;
    assign req.busy          = busy_q;
    assign req.done          = done_q;
    assign req.data_received = data_rx_q;
    assign dbg_state         = state_q;

endmodule

// File: tb/tb_adxl362_controller.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_adxl362_controller
//   Drives register reads/writes into adxl362_controller, with a behavioural
//   ADXL362 register-file model on the SPI pins and a reference model of the
//   expected returned data.
// -----------------------------------------------------------------------------
module tb_adxl362_controller;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT ----------------
    adxl362_controller_if bus ();
    logic       SPI_SCLK;
    logic       SPI_MOSI;
    logic       SPI_CS;
    logic       SPI_MISO = 1'b0;
    logic [2:0] dbg_state;

    adxl362_controller #(
        .CLK_FREQUENCY (100_000_000),
        .SCLK_FREQUENCY(1_000_000)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (bus),
        .SPI_SCLK (SPI_SCLK),
        .SPI_MOSI (SPI_MOSI),
        .SPI_MISO (SPI_MISO),
        .SPI_CS   (SPI_CS),
        .dbg_state(dbg_state)
    );

    // ---------------- ADXL362 device model ----------------
    logic [7:0]  dev_mem [0:255];
    logic [23:0] s_shift  = 24'h0;
    int          s_bits   = 0;
    logic [7:0]  s_rd     = 8'h00;
    int          s_frames = 0;
    logic [23:0] s_last   = 24'h0;

    always @(negedge SPI_CS) begin
        s_bits  = 0;
        s_shift = 24'h0;
    end

    always @(posedge SPI_SCLK) begin
        if (!SPI_CS) begin
            s_shift = {s_shift[22:0], SPI_MOSI};
            s_bits++;
            if (s_bits == 16) s_rd = dev_mem[s_shift[7:0]];
        end
    end

    // Mode 0: device updates MISO on the falling edge, data byte MSB first.
    always @(negedge SPI_SCLK) begin
        if (!SPI_CS && s_bits >= 16 && s_bits < 24) SPI_MISO = s_rd[23 - s_bits];
    end

    // Only a complete 24-bit frame is committed.
    always @(posedge SPI_CS) begin
        if (s_bits == 24) begin
            s_frames++;
            s_last = s_shift;
            if (s_shift[23:16] == 8'h0A) dev_mem[s_shift[15:8]] = s_shift[7:0];
        end
        s_bits = 0;
    end

    // ---------------- reference model ----------------
    logic [7:0] ref_mem [0:255];
    logic [7:0] ref_rx = 8'h00;

    task automatic ref_apply(input logic w, input logic [7:0] a, input logic [7:0] d);
        if (w) ref_mem[a] = d;
        else   ref_rx     = ref_mem[a];
    endtask

    function automatic logic [23:0] ref_bits(input logic w, input logic [7:0] a, input logic [7:0] d);
        return {w ? 8'h0A : 8'h0B, a, w ? d : 8'h00};
    endfunction

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- frame driver / monitor ----------------
    typedef struct {
        int   done_cnt;
        int   latency;
        int   cs_low;
        int   windows;
        int   rises;
        int   per_min;
        int   per_max;
        logic busy0;
        logic busy_end;
        logic timeout;
    } frame_res_t;

    task automatic run_frame(input logic w, input logic [7:0] a, input logic [7:0] d,
                             input int poke_at, output frame_res_t r);
        int   t0;
        int   last_rise;
        logic prev_sclk;
        logic prev_cs;
        r = '{default: 0};
        r.per_min = 1000000;
        r.timeout = 1'b1;
        last_rise = -1;
        prev_sclk = 1'b0;
        prev_cs   = 1'b1;
        @(negedge clk);
        bus.start = 1'b1; bus.write = w; bus.address = a; bus.data_to_send = d;
        t0 = cyc;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (i == 0) r.busy0 = bus.busy;
            if (!SPI_CS) r.cs_low++;
            if (!SPI_CS && prev_cs) r.windows++;
            if (SPI_SCLK && !prev_sclk) begin
                r.rises++;
                if (last_rise >= 0) begin
                    if (cyc - last_rise < r.per_min) r.per_min = cyc - last_rise;
                    if (cyc - last_rise > r.per_max) r.per_max = cyc - last_rise;
                end
                last_rise = cyc;
            end
            if (bus.done) begin
                if (r.done_cnt == 0) r.latency = cyc - (t0 + 1);
                r.done_cnt++;
            end
            prev_sclk = SPI_SCLK;
            prev_cs   = SPI_CS;
            if (i == 0) bus.start = 1'b0;
            if (poke_at > 0 && i == poke_at)     bus.start = 1'b1;
            if (poke_at > 0 && i == poke_at + 1) bus.start = 1'b0;
            if (r.done_cnt > 0 && !bus.busy) begin
                r.timeout = 1'b0;
                break;
            end
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.done) r.done_cnt++;
            if (!SPI_CS && prev_cs) r.windows++;
            prev_cs = SPI_CS;
        end
        r.busy_end = bus.busy;
    endtask

    task automatic check_frame(input string tag, input frame_res_t r, input logic [23:0] exp_bits,
                               input logic [7:0] exp_rx, input int frames_before);
        check({tag, " timeout"},  32'(r.timeout),  32'd0);
        check({tag, " busy0"},    32'(r.busy0),    32'd1);
        check({tag, " busy_end"}, 32'(r.busy_end), 32'd0);
        check({tag, " done_cnt"}, r.done_cnt,      32'd1);
        check({tag, " latency"},  r.latency,       32'd2451);
        check({tag, " cs_low"},   r.cs_low,        32'd2450);
        check({tag, " windows"},  r.windows,       32'd1);
        check({tag, " rises"},    r.rises,         32'd24);
        check({tag, " per_min"},  r.per_min,       32'd100);
        check({tag, " per_max"},  r.per_max,       32'd100);
        check({tag, " frames"},   s_frames,        frames_before + 1);
        check({tag, " mosi"},     32'(s_last),     32'(exp_bits));
        check({tag, " rx"},       32'(bus.data_received), 32'(exp_rx));
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       w;
        logic [7:0] a;
        logic [7:0] d;
        logic [23:0] exp_bits;
        logic [7:0] exp_rx;
    } vec_t;

    vec_t vecs [6];

    initial begin
        frame_res_t r;
        int         fb;
        logic       w;
        logic [7:0] a;
        logic [7:0] d;
        int         dn;

        vecs[0] = '{1'b0, 8'h00, 8'h77, 24'h0B0000, 8'hAD};
        vecs[1] = '{1'b0, 8'h01, 8'h00, 24'h0B0100, 8'h1D};
        vecs[2] = '{1'b0, 8'h02, 8'h00, 24'h0B0200, 8'hF2};
        vecs[3] = '{1'b1, 8'h1F, 8'h52, 24'h0A1F52, 8'hF2};
        vecs[4] = '{1'b1, 8'h2C, 8'h13, 24'h0A2C13, 8'hF2};
        vecs[5] = '{1'b0, 8'h2C, 8'h00, 24'h0B2C00, 8'h13};

        for (int i = 0; i < 256; i++) begin
            dev_mem[i] = 8'((i * 37 + 11) & 255);
            ref_mem[i] = 8'((i * 37 + 11) & 255);
        end
        dev_mem[0] = 8'hAD; ref_mem[0] = 8'hAD;
        dev_mem[1] = 8'h1D; ref_mem[1] = 8'h1D;
        dev_mem[2] = 8'hF2; ref_mem[2] = 8'hF2;

        bus.start = 1'b0; bus.write = 1'b0; bus.address = 8'h00; bus.data_to_send = 8'h00;

        // reset state
        repeat (3) @(negedge clk);
        check("rst cs",   32'(SPI_CS),   32'd1);
        check("rst sclk", 32'(SPI_SCLK), 32'd0);
        check("rst mosi", 32'(SPI_MOSI), 32'd0);
        check("rst busy", 32'(bus.busy), 32'd0);
        check("rst done", 32'(bus.done), 32'd0);
        check("rst rx",   32'(bus.data_received), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // table-driven frames
        for (int i = 0; i < 6; i++) begin
            fb = s_frames;
            run_frame(vecs[i].w, vecs[i].a, vecs[i].d, 0, r);
            ref_apply(vecs[i].w, vecs[i].a, vecs[i].d);
            check_frame($sformatf("vec%0d", i), r, vecs[i].exp_bits, vecs[i].exp_rx, fb);
        end

        // start pulsed again mid-frame is ignored
        fb = s_frames;
        run_frame(1'b0, 8'h01, 8'h00, 500, r);
        ref_apply(1'b0, 8'h01, 8'h00);
        check_frame("poke", r, 24'h0B0100, 8'h1D, fb);

        // randomized frames against the reference model
        for (int i = 0; i < 5; i++) begin
            w = 1'($urandom_range(0, 1));
            if (w || $urandom_range(0, 3) != 0) a = 8'h20 + 8'($urandom_range(0, 7));
            else                                a = 8'($urandom_range(0, 2));
            d = 8'($urandom_range(0, 255));
            fb = s_frames;
            run_frame(w, a, d, 0, r);
            ref_apply(w, a, d);
            check_frame($sformatf("rand%0d", i), r, ref_bits(w, a, d), ref_rx, fb);
        end

        // reset in the middle of a read
        fb = s_frames;
        @(negedge clk);
        bus.start = 1'b1; bus.write = 1'b0; bus.address = 8'h00; bus.data_to_send = 8'h00;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (999) @(negedge clk);
        check("midrst cs_before", 32'(SPI_CS), 32'd0);
        rst_n = 1'b0;
        #1;
        check("midrst cs",   32'(SPI_CS),   32'd1);
        check("midrst sclk", 32'(SPI_SCLK), 32'd0);
        check("midrst busy", 32'(bus.busy), 32'd0);
        dn = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.done) dn++;
        end
        rst_n = 1'b1;
        repeat (50) begin
            @(negedge clk);
            if (bus.done) dn++;
        end
        check("midrst done",   dn, 32'd0);
        check("midrst frames", s_frames, fb);
        check("midrst rx",     32'(bus.data_received), 32'd0);
        check("midrst idle_cs", 32'(SPI_CS), 32'd1);
        ref_rx = 8'h00;

        fb = s_frames;
        run_frame(1'b0, 8'h00, 8'h00, 0, r);
        ref_apply(1'b0, 8'h00, 8'h00);
        check_frame("after_rst", r, 24'h0B0000, ref_rx, fb);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
